mips_cpu_fetch_sequencer: RTL
=============================

// Module: mips_cpu_fetch_sequencer
// PURPOSE
//  Multi-cycle control FSM that owns the program counter and the single Avalon-style memory port.
//  Fetches the instruction at pc and hands it to the datapath, then waits for the datapath to finish.
//  Serves at most one datapath load/store per instruction, on the same shared bus.
//  Applies branch/jump targets after the delay slot completes; halts on a jump to HALT_ADDR.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  pc value loaded on reset
//  HALT_ADDR     32'h00000000  target address that stops the CPU
//  PC_STEP       4             sequential pc increment (bytes)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  reset           in   1   synchronous, active-high
//  active          out  1   1 while running; 0 once halted
//  pc              out  32  address of the instruction currently held
//  mem_address     out  32  bus address (pc during fetch, dp_addr during data)
//  mem_read        out  1   bus read strobe
//  mem_write       out  1   bus write strobe
//  mem_byteenable  out  4   byte lanes; 4'hF on fetch
//  mem_writedata   out  32  store data (dp_wdata)
//  mem_waitrequest in   1   1 = slave stalls; hold all bus outputs stable
//  mem_readdata    in   32  read return, valid in the cycle waitrequest==0
//  instr           out  32  latched instruction word
//  instr_valid     out  1   1-cycle pulse: new instr available (entry to EXEC)
//  exec_done       in   1   datapath finished an instruction with no memory access
//  branch_taken    in   1   qualifies branch_target; sampled with exec_done/dp_req
//  branch_target   in   32  redirect address
//  dp_req          in   1   datapath requests one data access (ends the instruction)
//  dp_write        in   1   1 = store, 0 = load
//  dp_addr         in   32  data address
//  dp_wdata        in   32  store data
//  dp_be           in   4   store/load byte enables
//  dp_ack          out  1   1-cycle pulse: data access complete
//  dp_rdata        out  32  load data, valid with dp_ack
// BEHAVIOUR
//  States: FETCH, EXEC, DATA, HALTED.
//  Reset: state=FETCH, pc=RESET_VECTOR, active=1, instr=0, delay_pending=0, tgt=0.
//   Reset outputs: instr_valid=0, dp_ack=0, dp_rdata=0, mem_write=0, mem_byteenable=4'hF, mem_writedata=0.
//   mem_read/mem_address follow the FETCH rules below.
//  Reset mid-bus-transaction abandons it; the next cycle is a fresh FETCH.
//  FETCH:
//   Drive mem_read=1, mem_address=pc, mem_byteenable=4'hF.
//   Stay while waitrequest=1.
//   When waitrequest=0: instr<=mem_readdata; go to EXEC; instr_valid=1 on the first EXEC cycle only.
//  EXEC:
//   No bus strobes.
//   exec_done=1: instruction completes this cycle.
//   dp_req=1: latch dp_write/dp_addr/dp_wdata/dp_be, and branch_taken/branch_target if asserted; go to DATA.
//   exec_done and dp_req both 1: dp_req wins.
//  DATA:
//   Drive mem_read=~dp_write or mem_write=dp_write, plus the latched addr/data/be.
//   Stay while waitrequest=1.
//   When waitrequest=0: dp_ack=1 and dp_rdata<=mem_readdata (loads; stores return 0).
//   The instruction completes the same cycle.
//  Completion (from EXEC or DATA):
//   delay_pending=1: pc<=tgt, delay_pending<=0. Any branch_taken in the delay slot is ignored.
//   Otherwise pc<=pc+PC_STEP (32-bit wrap). If branch_taken, also tgt<=branch_target, delay_pending<=1.
//   Next state FETCH, except: target applied equals HALT_ADDR -> HALTED, pc<=HALT_ADDR.
//  HALTED:
//   active=0, no bus strobes, all inputs ignored. Leave only via reset.
//  Latency, zero wait states: fetch 1 cycle, EXEC >=1 cycle, DATA 1 cycle. Each wait cycle adds 1.
//  Branch and delay slot both complete -> target fetch issues on the next cycle.
//  Bus outputs are held stable while waitrequest=1; no new request until the current one completes.
// TESTING
//  T1 reset, waitrequest=0, exec_done each EXEC
//     -> fetch addrs BFC00000, BFC00004, BFC00008; instr_valid once per fetch.
//  T2 waitrequest high 3 cycles during FETCH
//     -> mem_address/mem_read held for 4 cycles; instr latched only on the 4th.
//  T3 branch_taken to 0xBFC00100 at pc BFC00004
//     -> next fetch BFC00008 (delay slot), then BFC00100.
//  T4 load dp_addr=0x1000, readdata 0xDEADBEEF, 2 waits
//     -> mem_read held 3 cycles, dp_ack pulse, dp_rdata=0xDEADBEEF, pc+4.
//  T5 jump to 0x0, delay slot is a store
//     -> store completes, then active=0, no further mem_read/mem_write.
//  T6 reset asserted mid-DATA with waitrequest=1
//     -> next cycle fetch from BFC00000, mem_write=0, delay_pending cleared.

Source files
------------

// File: rtl/mips_cpu_fetch_sequencer.sv
// mips_cpu_fetch_sequencer
// Multi-cycle control FSM for a MIPS-style core. It owns the program counter
// and the single shared Avalon-style memory port. Each instruction is fetched,
// handed to the datapath, and optionally followed by one data access. Branch
// and jump targets take effect only after the delay slot has completed. A jump
// to HALT_ADDR parks the sequencer until the next reset.

module mips_cpu_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic        clk,
    input  logic        reset,

    output logic        active,
    output logic [31:0] pc,

    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,

    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,

    input  logic        dp_req,
    input  logic        dp_write,
    input  logic [31:0] dp_addr,
    input  logic [31:0] dp_wdata,
    input  logic [3:0]  dp_be,
    output logic        dp_ack,
    output logic [31:0] dp_rdata
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_DATA   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_active;
    logic [31:0] r_instr;
    logic        r_instrValid;

    // Pending redirect: target captured by a taken branch, applied once the
    // delay-slot instruction completes.
    logic        r_delayPending;
    logic [31:0] r_tgt;

    // Data access captured at the EXEC->DATA hand-off so the bus stays stable
    // even if the datapath changes its request lines while we wait.
    logic        r_dWrite;
    logic [31:0] r_dAddr;
    logic [31:0] r_dWdata;
    logic [3:0]  r_dBe;
    logic        r_dBrTaken;
    logic [31:0] r_dBrTarget;

    logic        r_dpAck;
    logic [31:0] r_dpRdata;

    logic        w_complete;
    logic        w_brTaken;
    logic [31:0] w_brTarget;
    logic [31:0] w_pcNext;
    logic [31:0] w_tgtNext;
    logic        w_pendNext;
    logic        w_halt;

    // Instruction completion: EXEC finishing without a data access, or the
    // data access being accepted by the slave. The branch qualifier comes from
    // the live inputs in EXEC and from the captured copy in DATA.
    always_comb begin
        w_complete = 1'b0;
        w_brTaken  = branch_taken;
        w_brTarget = branch_target;
        if (r_state == S_EXEC) begin
            w_complete = exec_done && !dp_req;
        end else if (r_state == S_DATA) begin
            w_complete = !mem_waitrequest;
            w_brTaken  = r_dBrTaken;
            w_brTarget = r_dBrTarget;
        end
    end

    // Next program counter and redirect bookkeeping for a completing
    // instruction. A delay-slot instruction cannot start a new redirect.
    always_comb begin
        w_pcNext   = r_pc + PC_STEP;
        w_tgtNext  = r_tgt;
        w_pendNext = 1'b0;
        w_halt     = 1'b0;
        if (r_delayPending) begin
            w_pcNext   = r_tgt;
            w_pendNext = 1'b0;
            w_halt     = (r_tgt == HALT_ADDR);
        end else if (w_brTaken) begin
            w_tgtNext  = w_brTarget;
            w_pendNext = 1'b1;
        end
    end

    // Main sequencer: state, pc, latched instruction, data hand-off and the
    // one-cycle instr_valid / dp_ack pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_FETCH;
            r_pc           <= RESET_VECTOR;
            r_active       <= 1'b1;
            r_instr        <= 32'd0;
            r_instrValid   <= 1'b0;
            r_delayPending <= 1'b0;
            r_tgt          <= 32'd0;
            r_dWrite       <= 1'b0;
            r_dAddr        <= 32'd0;
            r_dWdata       <= 32'd0;
            r_dBe          <= 4'hF;
            r_dBrTaken     <= 1'b0;
            r_dBrTarget    <= 32'd0;
            r_dpAck        <= 1'b0;
            r_dpRdata      <= 32'd0;
        end else begin
            r_instrValid <= 1'b0;
            r_dpAck      <= 1'b0;

            case (r_state)
                S_FETCH: begin
                    if (!mem_waitrequest) begin
                        r_instr      <= mem_readdata;
                        r_instrValid <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (dp_req) begin
                        r_dWrite   <= dp_write;
                        r_dAddr    <= dp_addr;
                        r_dWdata   <= dp_wdata;
                        r_dBe      <= dp_be;
                        r_dBrTaken <= branch_taken;
                        if (branch_taken) begin
                            r_dBrTarget <= branch_target;
                        end
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!mem_waitrequest) begin
                        r_dpAck   <= 1'b1;
                        r_dpRdata <= r_dWrite ? 32'd0 : mem_readdata;
                    end
                end
                default: begin
                end
            endcase

            if (w_complete) begin
                r_delayPending <= w_pendNext;
                r_tgt          <= w_tgtNext;
                if (w_halt) begin
                    r_pc     <= HALT_ADDR;
                    r_state  <= S_HALTED;
                    r_active <= 1'b0;
                end else begin
                    r_pc    <= w_pcNext;
                    r_state <= S_FETCH;
                end
            end
        end
    end

    // Bus strobes are decoded from registered state only, so they cannot
    // change while the slave holds waitrequest.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = r_pc;
        mem_byteenable = 4'hF;
        mem_writedata  = 32'd0;
        case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
            end
            S_DATA: begin
                mem_read       = !r_dWrite;
                mem_write      = r_dWrite;
                mem_address    = r_dAddr;
                mem_byteenable = r_dBe;
                mem_writedata  = r_dWrite ? r_dWdata : 32'd0;
            end
            default: begin
            end
        endcase
    end

    assign active      = r_active;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instrValid;
    assign dp_ack      = r_dpAck;
    assign dp_rdata    = r_dpRdata;

endmodule
